// File: rtl/link_scan_pkg.sv
// Shared types and constants for the per-link input-delay scanner.
// Holds the scan FSM state encoding and tap-range helpers.
package link_scan_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SET,
    S_WAIT_RDY,
    S_CLR,
    S_DWELL,
    S_SAMPLE,
    S_NEXT_TAP,
    S_APPLY,
    S_APPLY_RDY,
    S_NEXT_LINK,
    S_FIN
  } scan_state_t;

  localparam int RDY_TMO_DEF = 256;

  function automatic int delay_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/link_delay_scan_ctrl_tracker.sv
// Longest error-free tap window tracker.
// Ties keep the earlier run; a run is closed by a bad tap or end of range.
module scan_window_tracker
  import link_scan_pkg::*;
#(
  parameter int DELAY_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic               good,
  input  logic [DELAY_W-1:0] tap,
  input  logic               close,
  output logic [DELAY_W-1:0] best_first,
  output logic [DELAY_W-1:0] best_last,
  output logic [DELAY_W:0]   best_len
);

  logic               open_q, open_d;
  logic [DELAY_W-1:0] run_start_q, run_start_d;
  logic [DELAY_W-1:0] run_last_q, run_last_d;
  logic [DELAY_W:0]   run_len_q, run_len_d;
  logic [DELAY_W-1:0] bf_q, bf_d;
  logic [DELAY_W-1:0] bl_q, bl_d;
  logic [DELAY_W:0]   bn_q, bn_d;
  logic               close_run;

  always_comb begin
    open_d      = open_q;
    run_start_d = run_start_q;
    run_last_d  = run_last_q;
    run_len_d   = run_len_q;
    bf_d        = bf_q;
    bl_d        = bl_q;
    bn_d        = bn_q;
    close_run   = 1'b0;
    if (clear) begin
      open_d      = 1'b0;
      run_start_d = '0;
      run_last_d  = '0;
      run_len_d   = '0;
      bf_d        = '0;
      bl_d        = '0;
      bn_d        = '0;
    end else begin
      if (sample_valid) begin
        if (good) begin
          if (!open_q) begin
            run_start_d = tap;
            run_len_d   = (DELAY_W+1)'(1);
            open_d      = 1'b1;
          end else begin
            run_len_d = run_len_q + 1'b1;
          end
          run_last_d = tap;
        end else begin
          close_run = 1'b1;
        end
      end else if (close) begin
        close_run = 1'b1;
      end
      if (close_run && open_q) begin
        // strict > so an equal-length later run never displaces the earlier one
        if (run_len_q > bn_q) begin
          bf_d = run_start_q;
          bl_d = run_last_q;
          bn_d = run_len_q;
        end
        open_d    = 1'b0;
        run_len_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      open_q      <= 1'b0;
      run_start_q <= '0;
      run_last_q  <= '0;
      run_len_q   <= '0;
      bf_q        <= '0;
      bl_q        <= '0;
      bn_q        <= '0;
    end else begin
      open_q      <= open_d;
      run_start_q <= run_start_d;
      run_last_q  <= run_last_d;
      run_len_q   <= run_len_d;
      bf_q        <= bf_d;
      bl_q        <= bl_d;
      bn_q        <= bn_d;
    end
  end

  assign best_first = bf_q;
  assign best_last  = bl_q;
  assign best_len   = bn_q;

endmodule

// File: rtl/link_delay_scan_ctrl.sv
// Per-link delay scan FSM: sweeps taps, integrates errors, and
// programs each enabled link to the centre of its widest clean window.
module link_delay_scan_ctrl
  import link_scan_pkg::*;
#(
  parameter int NLINKS  = 12,
  parameter int DELAY_W = 9,
  parameter int ERR_W   = 16,
  parameter int DWELL_W = 24,
  parameter int RDY_TMO = RDY_TMO_DEF
) (
  input  logic                            clk160,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NLINKS-1:0]               link_mask,
  input  logic [DELAY_W-1:0]              tap_step,
  input  logic [DWELL_W-1:0]              dwell_cycles,
  input  logic [ERR_W-1:0]                err_threshold,
  input  logic [NLINKS-1:0]               delay_ready,
  input  logic [NLINKS-1:0][ERR_W-1:0]    bit_align_errors,
  output logic [NLINKS-1:0][DELAY_W-1:0]  delay_in,
  output logic [NLINKS-1:0]               delay_set,
  output logic [NLINKS-1:0]               reset_counters,
  output logic [NLINKS-1:0][DELAY_W-1:0]  best_delay,
  output logic [NLINKS-1:0]               link_locked,
  output logic                            busy,
  output logic                            done
);

  localparam int CUR_W     = $clog2(NLINKS);
  localparam int TMO_W     = $clog2(RDY_TMO) + 1;
  localparam int DELAY_MAX = delay_max(DELAY_W);

  scan_state_t                    state_q, state_d;
  logic [CUR_W-1:0]               cur_q, cur_d;
  logic [NLINKS-1:0]              mask_q, mask_d;
  logic [DELAY_W-1:0]             step_q, step_d;
  logic [DELAY_W-1:0]             tap_q, tap_d;
  logic [TMO_W-1:0]               tmo_q, tmo_d;
  logic [DWELL_W-1:0]             dwell_q, dwell_d;
  logic [NLINKS-1:0][DELAY_W-1:0] din_q, din_d;
  logic [NLINKS-1:0]              set_q, set_d;
  logic [NLINKS-1:0]              rc_q, rc_d;
  logic [NLINKS-1:0][DELAY_W-1:0] best_q, best_d;
  logic [NLINKS-1:0]              lock_q, lock_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  logic               trk_clear, trk_valid, trk_close, good;
  logic [DELAY_W-1:0] best_first, best_last;
  logic [DELAY_W:0]   best_len;
  logic [DELAY_W:0]   sum, mid_sum;
  logic [CUR_W-1:0]   low;
  logic [NLINKS-1:0]  low_src;

  scan_window_tracker #(.DELAY_W(DELAY_W)) u_trk (
    .clk          (clk160),
    .rst          (rst),
    .clear        (trk_clear),
    .sample_valid (trk_valid),
    .good         (good),
    .tap          (tap_q),
    .close        (trk_close),
    .best_first   (best_first),
    .best_last    (best_last),
    .best_len     (best_len)
  );

  always_comb begin
    low_src = (state_q == S_IDLE) ? link_mask : mask_q;
    low     = '0;
    for (int i = NLINKS - 1; i >= 0; i--) begin
      if (low_src[i]) low = CUR_W'(i);
    end
  end

  assign good    = bit_align_errors[cur_q] <= err_threshold;
  assign sum     = {1'b0, tap_q} + {1'b0, step_q};
  assign mid_sum = {1'b0, best_first} + {1'b0, best_last};

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    mask_d    = mask_q;
    step_d    = step_q;
    tap_d     = tap_q;
    tmo_d     = tmo_q;
    dwell_d   = dwell_q;
    din_d     = din_q;
    set_d     = set_q;
    rc_d      = '0;
    best_d    = best_q;
    lock_d    = lock_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    trk_clear = 1'b0;
    trk_valid = 1'b0;
    trk_close = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = link_mask;
          step_d  = (tap_step == '0) ? DELAY_W'(1) : tap_step;
          busy_d  = 1'b1;
          cur_d   = low;
          state_d = S_NEXT_LINK;
        end
      end
      S_NEXT_LINK: begin
        if (mask_q == '0) begin
          state_d = S_FIN;
        end else begin
          cur_d       = low;
          lock_d[low] = 1'b0;
          tap_d       = '0;
          trk_clear   = 1'b1;
          state_d     = S_SET;
        end
      end
      S_SET: begin
        din_d[cur_q] = tap_q;
        set_d[cur_q] = 1'b1;
        tmo_d        = '0;
        state_d      = S_WAIT_RDY;
      end
      S_WAIT_RDY, S_APPLY_RDY: begin
        if (delay_ready[cur_q]) begin
          set_d[cur_q] = 1'b0;
          if (state_q == S_WAIT_RDY) begin
            rc_d[cur_q] = 1'b1;
            state_d     = S_CLR;
          end else begin
            lock_d[cur_q] = 1'b1;
            mask_d[cur_q] = 1'b0;
            state_d       = S_NEXT_LINK;
          end
        end else if (tmo_q == TMO_W'(RDY_TMO - 1)) begin
          set_d[cur_q]  = 1'b0;
          lock_d[cur_q] = 1'b0;
          if (state_q == S_WAIT_RDY) best_d[cur_q] = '0;
          mask_d[cur_q] = 1'b0;
          state_d       = S_NEXT_LINK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CLR: begin
        dwell_d = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (dwell_q <= DWELL_W'(1)) state_d = S_SAMPLE;
        else dwell_d = dwell_q - 1'b1;
      end
      S_SAMPLE: begin
        trk_valid = 1'b1;
        state_d   = S_NEXT_TAP;
      end
      S_NEXT_TAP: begin
        if (int'(sum) > DELAY_MAX) begin
          trk_close = 1'b1;
          state_d   = S_APPLY;
        end else begin
          tap_d   = sum[DELAY_W-1:0];
          state_d = S_SET;
        end
      end
      S_APPLY: begin
        if (best_len == '0) begin
          lock_d[cur_q] = 1'b0;
          best_d[cur_q] = '0;
          din_d[cur_q]  = '0;
          mask_d[cur_q] = 1'b0;
          state_d       = S_NEXT_LINK;
        end else begin
          best_d[cur_q] = mid_sum[DELAY_W:1];
          din_d[cur_q]  = mid_sum[DELAY_W:1];
          set_d[cur_q]  = 1'b1;
          tmo_d         = '0;
          state_d       = S_APPLY_RDY;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk160) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      mask_q  <= '0;
      step_q  <= '0;
      tap_q   <= '0;
      tmo_q   <= '0;
      dwell_q <= '0;
      din_q   <= '0;
      set_q   <= '0;
      rc_q    <= '0;
      best_q  <= '0;
      lock_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      mask_q  <= mask_d;
      step_q  <= step_d;
      tap_q   <= tap_d;
      tmo_q   <= tmo_d;
      dwell_q <= dwell_d;
      din_q   <= din_d;
      set_q   <= set_d;
      rc_q    <= rc_d;
      best_q  <= best_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign delay_in       = din_q;
  assign delay_set      = set_q;
  assign reset_counters = rc_q;
  assign best_delay     = best_q;
  assign link_locked    = lock_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_link_delay_scan_ctrl.sv
// Directed bench for link_delay_scan_ctrl with a per-link error model
// and a queue of expected per-link results checked on each done pulse.
module tb_link_delay_scan_ctrl;

  localparam int NL = 12;
  localparam int DW = 9;
  localparam int EW = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [NL-1:0]          link_mask;
  logic [DW-1:0]          tap_step;
  logic [23:0]            dwell_cycles;
  logic [EW-1:0]          err_threshold;
  logic [NL-1:0]          delay_ready;
  logic [NL-1:0][EW-1:0]  bit_align_errors;
  logic [NL-1:0][DW-1:0]  delay_in;
  logic [NL-1:0]          delay_set;
  logic [NL-1:0]          reset_counters;
  logic [NL-1:0][DW-1:0]  best_delay;
  logic [NL-1:0]          link_locked;
  logic                   busy;
  logic                   done;

  link_delay_scan_ctrl dut (
    .clk160           (clk),
    .rst              (rst),
    .start            (start),
    .link_mask        (link_mask),
    .tap_step         (tap_step),
    .dwell_cycles     (dwell_cycles),
    .err_threshold    (err_threshold),
    .delay_ready      (delay_ready),
    .bit_align_errors (bit_align_errors),
    .delay_in         (delay_in),
    .delay_set        (delay_set),
    .reset_counters   (reset_counters),
    .best_delay       (best_delay),
    .link_locked      (link_locked),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int lo1 [NL];
  int hi1 [NL];
  int lo2 [NL];
  int hi2 [NL];
  bit stuck [NL];

  function automatic bit is_bad(input int j, input int t);
    return !((t >= lo1[j] && t <= hi1[j]) || (t >= lo2[j] && t <= hi2[j]));
  endfunction

  logic [EW-1:0] ecnt [NL];

  for (genvar g = 0; g < NL; g++) begin : g_link
    assign delay_ready[g]      = !stuck[g];
    assign bit_align_errors[g] = ecnt[g];
  end

  always @(posedge clk) begin
    for (int j = 0; j < NL; j++) begin
      if (rst || reset_counters[j]) ecnt[j] <= '0;
      else if (is_bad(j, int'(delay_in[j]))) ecnt[j] <= ecnt[j] + 1'b1;
    end
  end

  logic          mon_clr;
  int            rises [NL];
  int            set_hi [NL];
  int            done_cnt;
  bit            any_set;
  logic [NL-1:0] set_prev;

  always @(posedge clk) begin
    if (mon_clr) begin
      for (int j = 0; j < NL; j++) begin
        rises[j]  <= 0;
        set_hi[j] <= 0;
      end
      done_cnt <= 0;
      any_set  <= 1'b0;
    end else begin
      for (int j = 0; j < NL; j++) begin
        if (delay_set[j] && !set_prev[j]) rises[j] <= rises[j] + 1;
        if (delay_set[j]) set_hi[j] <= set_hi[j] + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (|delay_set) any_set <= 1'b1;
    end
    set_prev <= delay_set;
  end

  typedef struct {
    int link;
    int best;
    bit locked;
    int din;
    bit chk_din;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int l, input int b, input bit lk,
                      input int d, input bit cd);
    exp_t e;
    e.link    = l;
    e.best    = b;
    e.locked  = lk;
    e.din     = d;
    e.chk_din = cd;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s_best%0d", tag, e.link),
            64'(best_delay[e.link]), 64'(e.best));
      check($sformatf("%s_lock%0d", tag, e.link),
            64'(link_locked[e.link]), 64'(e.locked));
      if (e.chk_din)
        check($sformatf("%s_din%0d", tag, e.link),
              64'(delay_in[e.link]), 64'(e.din));
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic run_scan(input string tag, input logic [NL-1:0] mask,
                          input int step, input int dwell,
                          input int budget, input int extra_at,
                          output int lat);
    @(negedge clk);
    link_mask    = mask;
    tap_step     = DW'(step);
    dwell_cycles = 24'(dwell);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < budget) begin
      start     = (lat == extra_at);
      link_mask = (lat == extra_at) ? '1 : mask;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_din"},  64'(|delay_in), 64'd0);
    check({tag, "_set"},  64'(|delay_set), 64'd0);
    check({tag, "_rc"},   64'(|reset_counters), 64'd0);
    check({tag, "_best"}, 64'(|best_delay), 64'd0);
    check({tag, "_lock"}, 64'(|link_locked), 64'd0);
    check({tag, "_bd"},   64'({busy, done}), 64'd0);
  endtask

  initial begin
    int lat;
    int w;
    rst           = 1'b1;
    start         = 1'b0;
    mon_clr       = 1'b0;
    link_mask     = '0;
    tap_step      = DW'(1);
    dwell_cycles  = 24'd4;
    err_threshold = '0;
    for (int j = 0; j < NL; j++) begin
      lo1[j]   = -1;
      hi1[j]   = -2;
      lo2[j]   = -1;
      hi2[j]   = -2;
      stuck[j] = 1'b0;
    end
    lo1[0] = 100; hi1[0] = 200;
    lo1[3] = 10;  hi1[3] = 19;
    lo2[3] = 300; hi2[3] = 309;
    lo1[4] = 480; hi1[4] = 511;
    lo1[6] = 0;   hi1[6] = 40;
    lo1[2] = 200; hi1[2] = 263;
    stuck[5] = 1'b1;

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    clr_mon();

    run_scan("mask0", '0, 1, 4, 20, 0, lat);
    check("mask0_latency", 64'(lat), 64'd3);
    check("mask0_no_set", 64'(any_set), 64'd0);
    @(negedge clk);
    check("mask0_busy_low", 64'(busy), 64'd0);

    clr_mon();
    push(0, 150, 1'b1, 150, 1'b1);
    run_scan("win0", 12'h001, 1, 4, 20000, 0, lat);
    drain("win0");
    check("win0_set_count", 64'(rises[0]), 64'd513);

    clr_mon();
    push(3, 14, 1'b1, 14, 1'b1);
    push(0, 150, 1'b1, 150, 1'b1);
    run_scan("tie3", 12'h008, 1, 4, 20000, 0, lat);
    drain("tie3");

    clr_mon();
    push(4, 488, 1'b1, 488, 1'b1);
    run_scan("top4", 12'h010, 16, 0, 5000, 5, lat);
    drain("top4");
    check("top4_set_count", 64'(rises[4]), 64'd33);
    @(negedge clk);
    check("top4_one_done", 64'(done_cnt), 64'd1);
    check("top4_no_other_set", 64'(rises[0]), 64'd0);

    clr_mon();
    push(5, 0, 1'b0, 0, 1'b0);
    push(6, 20, 1'b1, 20, 1'b1);
    push(7, 0, 1'b0, 0, 1'b1);
    run_scan("tmo5", 12'h0E0, 8, 4, 5000, 0, lat);
    drain("tmo5");
    check("tmo5_set_cycles", 64'(set_hi[5]), 64'd256);

    @(negedge clk);
    link_mask    = 12'h004;
    tap_step     = DW'(4);
    dwell_cycles = 24'd4;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!reset_counters[2] && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("abort_rc2_seen", 64'(reset_counters[2]), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("abort");
    rst = 1'b0;
    clr_mon();
    repeat (50) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_no_set", 64'(any_set), 64'd0);

    clr_mon();
    push(2, 230, 1'b1, 230, 1'b1);
    push(0, 0, 1'b0, 0, 1'b1);
    run_scan("rescan2", 12'h004, 4, 4, 5000, 0, lat);
    drain("rescan2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
